// File: rtl/bph_pkg.sv
// Shared constants for the M_bus receive lock sequencer: state codes,
// line patterns and counter widths.
package bph_pkg;
   localparam logic [2:0] ST_OFF     = 3'd0;
   localparam logic [2:0] ST_RETRAIN = 3'd1;
   localparam logic [2:0] ST_HUNT    = 3'd2;
   localparam logic [2:0] ST_VERIFY  = 3'd3;
   localparam logic [2:0] ST_LOCKED  = 3'd4;

   localparam logic [9:0] SYNC_WORD_DEF = 10'h0FA;
   localparam logic [9:0] IDLE_WORD     = 10'h3FF;

   localparam int BIT_W   = 4;
   localparam int MATCH_W = 4;
   localparam int RST_W   = 8;
   localparam int TMO_W   = 16;
   localparam int IDLE_W  = 16;
endpackage

// File: rtl/bph_word_framer.sv
// Word framer: tracks bit position within the 10-bit frame once phase is
// frozen, flags the word boundary and captures framed words.
module bph_word_framer
   import bph_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       i_run,
   input  logic       i_deliver,
   input  logic [9:0] i_sdata,
   output logic       o_aligned,
   output logic [9:0] o_word_out,
   output logic       o_word_valid
);
   logic [BIT_W-1:0] r_bit_cnt;
   logic [9:0]       r_word_out;
   logic             r_word_valid;

   // Boundary: the tenth bit of the current word is now in the shift register.
   assign o_aligned    = i_run && (r_bit_cnt == BIT_W'(9));
   assign o_word_out   = r_word_out;
   assign o_word_valid = r_word_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bit_cnt    <= '0;
         r_word_out   <= '0;
         r_word_valid <= 1'b0;
      end else begin
         r_word_valid <= 1'b0;
         if (!i_run || o_aligned)
            r_bit_cnt <= '0;
         else
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
         if (o_aligned && i_deliver) begin
            r_word_out   <= i_sdata;
            r_word_valid <= 1'b1;
         end
      end
   end
endmodule

// File: rtl/bph_lock_ctrl.sv
// Acquisition/lock sequencer for the 4-phase oversampling front end:
// retrain pulses, sync hunt, aligned verify, and locked word delivery.
module bph_lock_ctrl
   import bph_pkg::*;
#(
   parameter logic [9:0]  SYNC_WORD = SYNC_WORD_DEF,
   parameter int          SYNC_CNT  = 3,
   parameter int          RST_CYC   = 8,
   parameter logic [15:0] HUNT_TMO  = 16'd4000,
   parameter logic [15:0] IDLE_MAX  = 16'd64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_en,
   input  logic [9:0] i_sdata_in,
   input  logic [1:0] i_phase_sel,
   output logic       o_phase_rst,
   output logic       o_phase_lock,
   output logic [9:0] o_word_out,
   output logic       o_word_valid,
   output logic       o_link_up,
   output logic [2:0] o_state_dbg,
   output logic [7:0] o_relock_cnt
);
   localparam logic [RST_W-1:0]   RST_LAST   = RST_W'(RST_CYC - 1);
   localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(SYNC_CNT - 1);
   localparam logic [TMO_W-1:0]   TMO_LAST   = HUNT_TMO - 16'd1;
   localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_MAX - 16'd1;

   logic [2:0]         r_state, w_nxt;
   logic [RST_W-1:0]   r_rst_cnt;
   logic [TMO_W-1:0]   r_tmo_cnt;
   logic [MATCH_W-1:0] r_match_cnt;
   logic [IDLE_W-1:0]  r_idle_cnt;
   logic [1:0]         r_phase_lat;
   logic               r_phase_rst, r_phase_lock, r_link_up;
   logic [7:0]         r_relock_cnt;
   logic               w_sync, w_idle, w_phase_chg, w_aligned, w_run, w_deliver;

   assign w_sync      = (i_sdata_in == SYNC_WORD);
   assign w_idle      = (i_sdata_in == IDLE_WORD);
   assign w_phase_chg = (i_phase_sel != r_phase_lat);
   assign w_run       = (r_state == ST_VERIFY) || (r_state == ST_LOCKED);
   assign w_deliver   = (r_state == ST_LOCKED);

   bph_word_framer u_framer (
      .clk          (clk),
      .reset        (reset),
      .i_run        (w_run),
      .i_deliver    (w_deliver),
      .i_sdata      (i_sdata_in),
      .o_aligned    (w_aligned),
      .o_word_out   (o_word_out),
      .o_word_valid (o_word_valid)
   );

   // Dropping enable overrides every other transition.
   always_comb begin
      w_nxt = r_state;
      if (!i_en)
         w_nxt = ST_OFF;
      else begin
         case (r_state)
            ST_OFF:     w_nxt = ST_RETRAIN;
            ST_RETRAIN: if (r_rst_cnt == RST_LAST) w_nxt = ST_HUNT;
            ST_HUNT: begin
               if (w_sync)
                  w_nxt = (SYNC_CNT == 1) ? ST_LOCKED : ST_VERIFY;
               else if (r_tmo_cnt == TMO_LAST)
                  w_nxt = ST_RETRAIN;
            end
            ST_VERIFY: begin
               if (w_phase_chg || (w_aligned && !w_sync))
                  w_nxt = ST_RETRAIN;
               else if (w_aligned && r_match_cnt == MATCH_LAST)
                  w_nxt = ST_LOCKED;
            end
            ST_LOCKED:
               if (w_phase_chg || (w_idle && r_idle_cnt == IDLE_LAST))
                  w_nxt = ST_RETRAIN;
            default:    w_nxt = ST_OFF;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_OFF;
         r_rst_cnt    <= '0;
         r_tmo_cnt    <= '0;
         r_match_cnt  <= '0;
         r_idle_cnt   <= '0;
         r_phase_lat  <= '0;
         r_phase_rst  <= 1'b1;
         r_phase_lock <= 1'b0;
         r_link_up    <= 1'b0;
         r_relock_cnt <= '0;
      end else begin
         r_state   <= w_nxt;
         r_rst_cnt <= (r_state == ST_RETRAIN && w_nxt == ST_RETRAIN) ? r_rst_cnt + RST_W'(1) : '0;
         r_tmo_cnt <= (r_state == ST_HUNT && w_nxt == ST_HUNT) ? r_tmo_cnt + TMO_W'(1) : '0;
         r_idle_cnt <= (r_state == ST_LOCKED && w_nxt == ST_LOCKED && w_idle)
                       ? r_idle_cnt + IDLE_W'(1) : '0;
         if (r_state == ST_HUNT)
            r_match_cnt <= w_sync ? MATCH_W'(1) : '0;
         else if (r_state == ST_VERIFY && w_aligned && w_sync)
            r_match_cnt <= r_match_cnt + MATCH_W'(1);
         else if (!w_run)
            r_match_cnt <= '0;
         if (r_state == ST_HUNT && w_sync)
            r_phase_lat <= i_phase_sel;
         if (r_state == ST_LOCKED && w_nxt != ST_LOCKED && r_relock_cnt != 8'hFF)
            r_relock_cnt <= r_relock_cnt + 8'd1;
         r_phase_rst  <= (w_nxt == ST_OFF) || (w_nxt == ST_RETRAIN);
         r_phase_lock <= (w_nxt == ST_VERIFY) || (w_nxt == ST_LOCKED);
         r_link_up    <= (w_nxt == ST_LOCKED);
      end
   end

   assign o_state_dbg  = r_state;
   assign o_phase_rst  = r_phase_rst;
   assign o_phase_lock = r_phase_lock;
   assign o_link_up    = r_link_up;
   assign o_relock_cnt = r_relock_cnt;
endmodule
